// File: rtl/mem_rq_arbiter_2to1.sv
// Purpose: round-robin share of one memory request/response port between two clients; an in-order owner FIFO routes responses back.
// Latency: a request accepted at edge N is on mem_rq in cycle N+1; responses pass through combinationally.
// Backpressure: requests are taken only with a free request slot and a credit (< OUTSTANDING in flight); mem_rs_ready follows the owning client.
module mem_rq_arbiter_2to1 #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  localparam int RQ_W       = ADDR_W + 1 + DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              c0_rq_valid,
  input  logic [RQ_W-1:0]   c0_rq,
  output logic              c0_rq_ready,
  output logic              c0_rs_valid,
  output logic [DATA_W-1:0] c0_rs,
  input  logic              c0_rs_ready,
  input  logic              c1_rq_valid,
  input  logic [RQ_W-1:0]   c1_rq,
  output logic              c1_rq_ready,
  output logic              c1_rs_valid,
  output logic [DATA_W-1:0] c1_rs,
  input  logic              c1_rs_ready,
  output logic              mem_rq_valid,
  output logic [RQ_W-1:0]   mem_rq,
  input  logic              mem_rq_ready,
  input  logic              mem_rs_valid,
  input  logic [DATA_W-1:0] mem_rs,
  output logic              mem_rs_ready,
  output logic              err_unexp_rs
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(OUTSTANDING);

  // Pointers wrap modulo OUTSTANDING so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [RQ_W-1:0]  rq_buf;
  logic             buf_valid;
  logic             prio;          // client that wins when both request
  logic             owner_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;           // in-flight count, includes the buffered request
  logic             err_q;

  logic can_take;
  logic any_valid;
  logic grant;
  logic accept;
  logic fifo_empty;
  logic head;
  logic rs_fire;
  logic pop;

  // Grant decision: a lone requester always wins, a tie goes to prio.
  always_comb begin
    can_take  = (!buf_valid || mem_rq_ready) && (cnt < MAX_CNT);
    any_valid = c0_rq_valid || c1_rq_valid;
    grant     = (c0_rq_valid && c1_rq_valid) ? prio : c1_rq_valid;
    accept    = can_take && any_valid;
  end

  assign c0_rq_ready  = accept && !grant;
  assign c1_rq_ready  = accept && grant;
  assign mem_rq_valid = buf_valid;
  assign mem_rq       = rq_buf;

  // Response routing uses the owner of the oldest in-flight request.
  assign fifo_empty   = (cnt == '0);
  assign head         = owner_q[rd_ptr];
  assign c0_rs_valid  = mem_rs_valid && !fifo_empty && !head;
  assign c1_rs_valid  = mem_rs_valid && !fifo_empty && head;
  assign c0_rs        = mem_rs;
  assign c1_rs        = mem_rs;
  // With nothing in flight, stray responses are swallowed rather than stalling memory.
  assign mem_rs_ready = fifo_empty ? 1'b1 : (head ? c1_rs_ready : c0_rs_ready);
  assign rs_fire      = mem_rs_valid && mem_rs_ready;
  assign pop          = rs_fire && !fifo_empty;
  assign err_unexp_rs = err_q;

  // Request stage: load on accept, empty when memory takes it; flip priority after every grant.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      buf_valid <= 1'b0;
      rq_buf    <= '0;
      prio      <= 1'b0;
    end else begin
      if (accept) begin
        rq_buf    <= grant ? c1_rq : c0_rq;
        buf_valid <= 1'b1;
        prio      <= !grant;
      end else if (mem_rq_ready) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // Owner FIFO: push the winner on accept, pop on a routed response handshake.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        owner_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (accept && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !accept) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Sticky flag for a response that arrives with nothing in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (rs_fire && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_rq_arbiter_2to1.sv
// Bench for mem_rq_arbiter_2to1: directed scenarios followed by a randomized run.
// A transaction-level model (queues of owners, memory requests and expected data) predicts every output.
// Memory answers each request with data derived from its address so misrouting is visible end to end.
module tb_mem_rq_arbiter_2to1;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OUT = 4;
  localparam int RQW = AW + 1 + DW;

  logic CLK = 1'b0;
  logic RST_N;
  logic c0_rq_valid, c0_rq_ready, c0_rs_valid, c0_rs_ready;
  logic c1_rq_valid, c1_rq_ready, c1_rs_valid, c1_rs_ready;
  logic [RQW-1:0] c0_rq, c1_rq, mem_rq;
  logic [DW-1:0]  c0_rs, c1_rs, mem_rs;
  logic mem_rq_valid, mem_rq_ready, mem_rs_valid, mem_rs_ready, err_unexp_rs;

  always #5 CLK = ~CLK;

  mem_rq_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(OUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c0_rq_valid(c0_rq_valid), .c0_rq(c0_rq), .c0_rq_ready(c0_rq_ready),
    .c0_rs_valid(c0_rs_valid), .c0_rs(c0_rs), .c0_rs_ready(c0_rs_ready),
    .c1_rq_valid(c1_rq_valid), .c1_rq(c1_rq), .c1_rq_ready(c1_rq_ready),
    .c1_rs_valid(c1_rs_valid), .c1_rs(c1_rs), .c1_rs_ready(c1_rs_ready),
    .mem_rq_valid(mem_rq_valid), .mem_rq(mem_rq), .mem_rq_ready(mem_rq_ready),
    .mem_rs_valid(mem_rs_valid), .mem_rs(mem_rs), .mem_rs_ready(mem_rs_ready),
    .err_unexp_rs(err_unexp_rs)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit             m_buf_vld, m_prio, m_err;
  logic [RQW-1:0] m_buf;
  bit             m_own[$];      // issuer of each in-flight request, oldest first
  logic [RQW-1:0] mem_q[$];      // requests the memory has taken, awaiting response
  logic [DW-1:0]  exp0[$], exp1[$];
  bit             iss_log[$], del_log[$];
  int             n_del[2];
  logic [DW-1:0]  last_rs[2];
  bit             rs_from_q, unexp_req;
  int             cl_left[2];
  int unsigned    cl_addr[2];
  int             cl_pct, rdy_pct, rs_pct, mrq_pct, wr_pct;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rs_of(input logic [RQW-1:0] rq);
    logic [AW-1:0] a;
    a = rq[RQW-1 -: AW];
    return a ^ 32'hDEADBEFF;
  endfunction

  function automatic bit idle();
    return (m_own.size() == 0) && (mem_q.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0) &&
           !c0_rq_valid && !c1_rq_valid && !m_buf_vld && !mem_rs_valid;
  endfunction

  task automatic mk_rq(input int x, output logic [RQW-1:0] rq);
    bit w;
    w  = ($urandom_range(99) < wr_pct);
    rq = {AW'(cl_addr[x]), w, DW'($urandom)};
    cl_addr[x] += 4;
  endtask

  task automatic set_mode(input int cl, input int rdy, input int rs, input int mrq, input int wr);
    cl_pct = cl; rdy_pct = rdy; rs_pct = rs; mrq_pct = mrq; wr_pct = wr;
  endtask

  // Present new client requests / memory responses; held payloads are never touched.
  task automatic gen_inputs();
    logic [RQW-1:0] rq;
    if (!c0_rq_valid && cl_left[0] > 0 && $urandom_range(99) < cl_pct) begin
      mk_rq(0, rq); c0_rq = rq; c0_rq_valid = 1'b1; cl_left[0]--;
    end
    if (!c1_rq_valid && cl_left[1] > 0 && $urandom_range(99) < cl_pct) begin
      mk_rq(1, rq); c1_rq = rq; c1_rq_valid = 1'b1; cl_left[1]--;
    end
    c0_rs_ready  = ($urandom_range(99) < rdy_pct);
    c1_rs_ready  = ($urandom_range(99) < rdy_pct);
    mem_rq_ready = ($urandom_range(99) < mrq_pct);
    if (!mem_rs_valid) begin
      if (unexp_req) begin
        mem_rs_valid = 1'b1; mem_rs = DW'($urandom); rs_from_q = 1'b0; unexp_req = 1'b0;
      end else if (mem_q.size() != 0 && $urandom_range(99) < rs_pct) begin
        mem_rs_valid = 1'b1; mem_rs = rs_of(mem_q[0]); rs_from_q = 1'b1;
      end
    end
  endtask

  // One clock: check every output against the model, advance the model, drive next inputs.
  task automatic cycle();
    bit e_ct, e_win, e_acc, e_rsv0, e_rsv1, e_rsr, e_mhs, e_rhs;
    logic [RQW-1:0] e_rq;
    logic [DW-1:0] d;
    #1;
    e_ct  = (!m_buf_vld || mem_rq_ready) && (m_own.size() < OUT);
    e_win = (c0_rq_valid && c1_rq_valid) ? m_prio : c1_rq_valid;
    e_acc = e_ct && (c0_rq_valid || c1_rq_valid);
    if (m_own.size() == 0) begin
      e_rsv0 = 1'b0; e_rsv1 = 1'b0; e_rsr = 1'b1;
    end else begin
      e_rsv0 = mem_rs_valid && !m_own[0];
      e_rsv1 = mem_rs_valid && m_own[0];
      e_rsr  = m_own[0] ? c1_rs_ready : c0_rs_ready;
    end
    chk("c0_rq_ready", c0_rq_ready, e_acc && !e_win);
    chk("c1_rq_ready", c1_rq_ready, e_acc && e_win);
    chk("mem_rq_valid", mem_rq_valid, m_buf_vld);
    if (m_buf_vld) chk("mem_rq", mem_rq, m_buf);
    chk("c0_rs_valid", c0_rs_valid, e_rsv0);
    chk("c1_rs_valid", c1_rs_valid, e_rsv1);
    chk("mem_rs_ready", mem_rs_ready, e_rsr);
    chk("err_unexp_rs", err_unexp_rs, m_err);
    if (e_rsv0 && c0_rs_ready) begin
      chk("c0_rs_expected", exp0.size() != 0, 1);
      if (exp0.size() != 0) begin d = exp0.pop_front(); chk("c0_rs_data", c0_rs, d); end
      del_log.push_back(1'b0); n_del[0]++; last_rs[0] = c0_rs;
    end
    if (e_rsv1 && c1_rs_ready) begin
      chk("c1_rs_expected", exp1.size() != 0, 1);
      if (exp1.size() != 0) begin d = exp1.pop_front(); chk("c1_rs_data", c1_rs, d); end
      del_log.push_back(1'b1); n_del[1]++; last_rs[1] = c1_rs;
    end
    e_mhs = m_buf_vld && mem_rq_ready;
    e_rhs = mem_rs_valid && e_rsr;
    e_rq  = e_win ? c1_rq : c0_rq;
    @(posedge CLK);
    #1;
    if (e_rhs) begin
      if (m_own.size() != 0) void'(m_own.pop_front());
      else m_err = 1'b1;
      if (rs_from_q && mem_q.size() != 0) void'(mem_q.pop_front());
      mem_rs_valid = 1'b0;
    end
    if (e_mhs) mem_q.push_back(m_buf);
    if (e_acc) begin
      m_own.push_back(e_win); iss_log.push_back(e_win);
      if (e_win) begin exp1.push_back(rs_of(e_rq)); c1_rq_valid = 1'b0; end
      else begin exp0.push_back(rs_of(e_rq)); c0_rq_valid = 1'b0; end
      m_buf = e_rq; m_buf_vld = 1'b1; m_prio = !e_win;
    end else if (mem_rq_ready) begin
      m_buf_vld = 1'b0;
    end
    gen_inputs();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    c0_rq_valid = 1'b0; c1_rq_valid = 1'b0; c0_rq = '0; c1_rq = '0;
    c0_rs_ready = 1'b0; c1_rs_ready = 1'b0;
    mem_rq_ready = 1'b0; mem_rs_valid = 1'b0; mem_rs = '0;
    m_buf_vld = 1'b0; m_prio = 1'b0; m_err = 1'b0; m_buf = '0;
    m_own.delete(); mem_q.delete(); exp0.delete(); exp1.delete();
    iss_log.delete(); del_log.delete();
    n_del = '{0, 0}; cl_left = '{0, 0}; rs_from_q = 1'b0; unexp_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mem_rq_valid", mem_rq_valid, 0);
    chk("rst_err", err_unexp_rs, 0);
    chk("rst_c0_rs_valid", c0_rs_valid, 0);
    chk("rst_c1_rs_valid", c1_rs_valid, 0);
    RST_N = 1'b1;
  endtask

  task automatic drain(input string tag);
    cl_left = '{0, 0};
    set_mode(0, 100, 100, 100, 0);
    gen_inputs();
    for (int i = 0; i < 400; i++) begin
      if (idle()) break;
      cycle();
    end
    chk({tag, "_drained"}, idle(), 1);
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    set_mode(0, 100, 100, 100, 0);
    gen_inputs();
    #1;
    chk("t1_c0_rq_ready", c0_rq_ready, 0);
    chk("t1_c1_rq_ready", c1_rq_ready, 0);
    chk("t1_mem_rs_ready", mem_rs_ready, 1);
    repeat (2) cycle();

    // 2: lone reader
    do_reset();
    cl_addr[0] = 32'h10;
    set_mode(100, 100, 100, 100, 0);
    cl_left[0] = 1;
    gen_inputs();
    cycle();
    chk("t2_mem_rq_valid", mem_rq_valid, 1);
    chk("t2_mem_rq_addr", mem_rq[RQW-1 -: AW], 32'h10);
    chk("t2_mem_rq_iswrite", mem_rq[DW], 0);
    repeat (4) cycle();
    chk("t2_c0_count", n_del[0], 1);
    chk("t2_c0_data", last_rs[0], 32'hDEADBEEF);
    chk("t2_c1_count", n_del[1], 0);

    // 3: contention alternates strictly, responses follow issue order
    do_reset();
    cl_addr[0] = 32'h100; cl_addr[1] = 32'h200;
    set_mode(100, 100, 100, 100, 50);
    cl_left = '{3, 3};
    gen_inputs();
    repeat (20) cycle();
    chk("t3_issue_cnt", iss_log.size(), 6);
    chk("t3_deliv_cnt", del_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < iss_log.size()) chk("t3_issue_order", iss_log[i], i % 2);
      if (i < del_log.size()) chk("t3_deliv_order", del_log[i], i % 2);
    end

    // 4: credit limit
    do_reset();
    cl_addr[1] = 32'h400;
    set_mode(100, 100, 0, 100, 0);
    cl_left = '{0, 10};
    gen_inputs();
    repeat (8) cycle();
    chk("t4_accepts", iss_log.size(), OUT);
    #1;
    chk("t4_c1_blocked", c1_rq_ready, 0);
    rs_pct = 100;
    gen_inputs();
    cycle();
    #1;
    chk("t4_c1_reopened", c1_rq_ready, 1);
    cycle();
    chk("t4_accepts_after", iss_log.size(), OUT + 1);
    drain("t4");

    // 5: response backpressure
    do_reset();
    cl_addr[0] = 32'h800;
    set_mode(100, 0, 100, 100, 1);
    cl_left = '{1, 0};
    gen_inputs();
    repeat (4) cycle();
    #1;
    chk("t5_c0_rs_valid", c0_rs_valid, 1);
    chk("t5_mem_rs_stalled", mem_rs_ready, 0);
    chk("t5_not_delivered", n_del[0], 0);
    rdy_pct = 100;
    gen_inputs();
    cycle();
    chk("t5_delivered", n_del[0], 1);
    chk("t5_data", last_rs[0], 32'h800 ^ 32'hDEADBEFF);
    #1;
    chk("t5_popped", mem_rs_ready, 1);
    drain("t5");

    // 6: unexpected response is swallowed and flagged until reset
    do_reset();
    set_mode(0, 100, 100, 100, 0);
    unexp_req = 1'b1;
    gen_inputs();
    #1;
    chk("t6_mem_rs_ready", mem_rs_ready, 1);
    chk("t6_c0_rs_valid", c0_rs_valid, 0);
    cycle();
    chk("t6_err_set", err_unexp_rs, 1);
    cl_addr[0] = 32'hA00; cl_addr[1] = 32'hB00;
    cl_left = '{2, 2};
    cl_pct = 100;
    gen_inputs();
    repeat (15) cycle();
    chk("t6_err_sticky", err_unexp_rs, 1);
    drain("t6");
    do_reset();

    // Randomized traffic with random backpressure on every port
    cl_addr[0] = 32'h1000_0000; cl_addr[1] = 32'h2000_0000;
    set_mode(60, 70, 50, 70, 50);
    cl_left = '{400, 400};
    gen_inputs();
    repeat (2000) cycle();
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
